uart_cmd_rcv: RTL and testbench
===============================

UART_CMD_RCV -- requirements
Module: uart_cmd_rcv

Interface
REQ-001 The block SHALL have parameter BAUD_DIV, default 2604, giving clk cycles per bit (50 MHz / 19200 baud); legal range is 8..4095.
REQ-002 The block SHALL have port clk, input, 1 bit: the system clock; all state is updated on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port RX, input, 1 bit: asynchronous serial line, 8N1, LSB first, idle high.
REQ-005 The block SHALL have port clr_cmd_rdy, input, 1 bit: consumer acknowledge that clears cmd_rdy.
REQ-006 The block SHALL have port cmd, output, 8 bits: last valid received byte, held stable between valid frames.
REQ-007 The block SHALL have port cmd_rdy, output, 1 bit: sticky flag meaning a new valid byte is available on cmd.
REQ-008 The block SHALL have port frm_err, output, 1 bit: one-cycle pulse for a frame whose stop bit sampled low.
REQ-009 The block SHALL have port overrun, output, 1 bit: one-cycle pulse when a valid frame completes while cmd_rdy is already 1.

Function
REQ-010 RX SHALL pass through a 2-flop synchronizer preset to 1; all decisions SHALL use the synchronized value rx_s.
REQ-011 The FSM SHALL have states IDLE, START, DATA and STOP.
REQ-012 IDLE -> START SHALL occur on an rx_s falling edge (previous 1, current 1 -> 0); the baud counter SHALL load BAUD_DIV/2 (integer division).
REQ-013 In START, when the baud counter reaches 0, rx_s SHALL be sampled: if 0, go to DATA with bit counter = 0 and baud counter = BAUD_DIV-1; if 1 (glitch), return to IDLE with no output change.
REQ-014 In DATA, each baud counter expiry SHALL sample rx_s into the shift register LSB-first and reload BAUD_DIV-1; after the 8th sample (bit counter 7) the FSM SHALL go to STOP.
REQ-015 In STOP, on baud counter expiry: if rx_s = 1, the frame is valid, the shifted byte SHALL load cmd, and the FSM SHALL return to IDLE; if rx_s = 0, frm_err SHALL pulse, cmd SHALL be unchanged, and the FSM SHALL go to IDLE.
REQ-016 After a framing error, IDLE SHALL wait for rx_s = 1 before it accepts a new falling edge; a held-low break line SHALL therefore not retrigger.
REQ-017 cmd_rdy SHALL rise on the clk edge that loads cmd, i.e. the cycle after the stop-bit sample.
REQ-018 cmd_rdy SHALL stay 1 until a cycle with clr_cmd_rdy = 1 and no concurrent valid-frame completion.
REQ-019 On a valid-frame completion in the same cycle as clr_cmd_rdy, set SHALL win: cmd_rdy stays 1 and cmd takes the new byte.
REQ-020 On a valid frame while cmd_rdy = 1 and clr_cmd_rdy = 0, cmd SHALL be overwritten with the new byte, cmd_rdy SHALL stay 1, and overrun SHALL pulse for one cycle.
REQ-021 clr_cmd_rdy while cmd_rdy = 0 SHALL have no effect; clr_cmd_rdy SHALL never abort a frame in progress.
REQ-022 Nominal latency, from the RX falling edge to the cmd_rdy rise, SHALL be 2 (sync) + 1 (edge detect) + BAUD_DIV/2 + 9*BAUD_DIV + 1 cycles.
REQ-023 The baud counter SHALL be 12 bits and the bit counter 3 bits; neither SHALL wrap outside its state's reload rules.

Reset
REQ-024 While rst = 1, the following SHALL hold: state IDLE, cmd = 8'h00, cmd_rdy = 0, frm_err = 0, overrun = 0, synchronizer flops = 1, counters = 0, shift register = 0.
REQ-025 Assertion of rst mid-frame SHALL abandon the frame immediately, with no cmd_rdy or frm_err pulse produced.
REQ-026 After rst deasserts, a frame SHALL only be accepted from a fresh falling edge, once rx_s has been seen high.

Verification (BAUD_DIV = 16 in all scenarios)
REQ-027 A bench SHALL send byte 8'h45 (GO, dest 5) as a valid 8N1 frame; required: cmd = 8'h45, and cmd_rdy rises exactly 2+1+8+144+1 = 156 cycles after the RX fall; frm_err = 0.
REQ-028 A bench SHALL send 8'hC3, wait with no clear, then send 8'h00; required: one overrun pulse, cmd = 8'h00, cmd_rdy remains 1; then clr_cmd_rdy for one cycle gives cmd_rdy = 0 on the next cycle.
REQ-029 A bench SHALL drive an RX low glitch of 5 cycles, then hold RX high; required: FSM back in IDLE, cmd_rdy = 0, frm_err = 0, cmd unchanged.
REQ-030 A bench SHALL send 8'hA5 with the stop bit forced low and RX held low for 40 more cycles, then release; required: exactly one frm_err pulse, cmd_rdy = 0, cmd = previous value, no new frame started.
REQ-031 A bench SHALL assert clr_cmd_rdy in the exact cycle the stop bit of 8'h7E completes; required: cmd_rdy = 1 and cmd = 8'h7E afterwards.
REQ-032 A bench SHALL assert rst for 3 cycles midway through the data bits of 8'hFF, then send 8'h12 cleanly; required: no output activity from the aborted frame, all outputs at reset values while rst = 1, then cmd = 8'h12 with cmd_rdy = 1.

Source files
------------

// File: rtl/uart_cmd_rcv.sv
// 8N1 UART receiver for single-byte commands: synchronizes RX, frames bytes LSB-first,
// and holds the last good byte on cmd with a sticky ready flag plus error/overrun pulses.
module uart_cmd_rcv #(
  parameter int BAUD_DIV = 2604
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       RX,
  input  logic       clr_cmd_rdy,
  output logic [7:0] cmd,
  output logic       cmd_rdy,
  output logic       frm_err,
  output logic       overrun
);

  localparam logic [11:0] HALF_DIV = 12'(BAUD_DIV / 2);
  localparam logic [11:0] FULL_DIV = 12'(BAUD_DIV - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t      state_r;
  logic        rx_meta_r;
  logic        rx_s;
  logic        rx_prev_r;
  logic        rx_armed_r;
  logic [11:0] baud_cnt_r;
  logic [2:0]  bit_cnt_r;
  logic [7:0]  shift_r;

  logic        fall_s;
  logic        baud_done_s;
  logic        frame_ok_s;
  logic        frame_bad_s;

  // Two-flop synchronizer plus one-cycle history for falling-edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_r <= 1'b1;
      rx_s      <= 1'b1;
      rx_prev_r <= 1'b1;
    end else begin
      rx_meta_r <= RX;
      rx_s      <= rx_meta_r;
      rx_prev_r <= rx_s;
    end
  end

  // Edge detect and stop-bit verdict
  always_comb begin
    fall_s      = rx_armed_r & rx_prev_r & ~rx_s;
    baud_done_s = (baud_cnt_r == 12'd0);
    frame_ok_s  = 1'b0;
    frame_bad_s = 1'b0;
    if ((state_r == STOP) && baud_done_s) begin
      frame_ok_s  = rx_s;
      frame_bad_s = ~rx_s;
    end else begin
      frame_ok_s  = 1'b0;
      frame_bad_s = 1'b0;
    end
  end

  // Receive FSM, counters, shift register and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      rx_armed_r <= 1'b0;
      baud_cnt_r <= 12'd0;
      bit_cnt_r  <= 3'd0;
      shift_r    <= 8'h00;
      cmd        <= 8'h00;
      cmd_rdy    <= 1'b0;
      frm_err    <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      frm_err <= frame_bad_s;
      overrun <= frame_ok_s & cmd_rdy & ~clr_cmd_rdy;

      // A new byte beats a concurrent clear so it is never lost
      if (frame_ok_s) begin
        cmd     <= shift_r;
        cmd_rdy <= 1'b1;
      end else if (clr_cmd_rdy) begin
        cmd_rdy <= 1'b0;
      end

      // A broken frame disarms edge detection until the line is seen idle again
      if (frame_bad_s) begin
        rx_armed_r <= 1'b0;
      end else if (rx_s) begin
        rx_armed_r <= 1'b1;
      end

      case (state_r)
        IDLE: begin
          if (fall_s) begin
            state_r    <= START;
            baud_cnt_r <= HALF_DIV;
          end
        end
        START: begin
          if (baud_done_s) begin
            if (!rx_s) begin
              state_r    <= DATA;
              bit_cnt_r  <= 3'd0;
              baud_cnt_r <= FULL_DIV;
            end else begin
              state_r <= IDLE;
            end
          end else begin
            baud_cnt_r <= baud_cnt_r - 12'd1;
          end
        end
        DATA: begin
          if (baud_done_s) begin
            shift_r    <= {rx_s, shift_r[7:1]};
            baud_cnt_r <= FULL_DIV;
            if (bit_cnt_r == 3'd7) begin
              state_r <= STOP;
            end else begin
              bit_cnt_r <= bit_cnt_r + 3'd1;
            end
          end else begin
            baud_cnt_r <= baud_cnt_r - 12'd1;
          end
        end
        STOP: begin
          if (baud_done_s) begin
            state_r <= IDLE;
          end else begin
            baud_cnt_r <= baud_cnt_r - 12'd1;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_cmd_rcv.sv
// Scoreboard bench for uart_cmd_rcv at BAUD_DIV=16: stimulus queues expected output
// events with their exact cycle, a negedge monitor pops and compares them.
module tb_uart_cmd_rcv;

  localparam int BAUD   = 16;
  localparam int LAT    = 156;
  localparam int K_LOAD = 0;
  localparam int K_OVR  = 1;
  localparam int K_FERR = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       RX;
  logic       clr_cmd_rdy;
  logic [7:0] cmd;
  logic       cmd_rdy;
  logic       frm_err;
  logic       overrun;

  uart_cmd_rcv #(.BAUD_DIV(BAUD)) dut (
    .clk        (clk),
    .rst        (rst),
    .RX         (RX),
    .clr_cmd_rdy(clr_cmd_rdy),
    .cmd        (cmd),
    .cmd_rdy    (cmd_rdy),
    .frm_err    (frm_err),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         kind;
    logic [7:0] data;
    int         at;
  } ev_t;

  ev_t exp_q[$];
  int  tests = 0;
  int  fails = 0;
  int  fall_cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic check_idle_outputs(input string tag, input logic [7:0] exp_cmd);
    check({tag, "_cmd"}, cmd, exp_cmd);
    check({tag, "_rdy"}, cmd_rdy, 1'b0);
    check({tag, "_ferr"}, frm_err, 1'b0);
    check({tag, "_ovr"}, overrun, 1'b0);
  endtask

  // Drive one 8N1 frame and queue the events it must produce
  task automatic send(input logic [7:0] b, input logic stop_ok, input logic exp_ovr,
                      input logic [7:0] old_cmd);
    @(posedge clk);
    #1 RX = 1'b0;
    fall_cyc = cyc;
    if (stop_ok) begin
      exp_q.push_back('{K_LOAD, b, fall_cyc + LAT});
      if (exp_ovr) exp_q.push_back('{K_OVR, b, fall_cyc + LAT});
    end else begin
      exp_q.push_back('{K_FERR, old_cmd, fall_cyc + LAT});
    end
    repeat (BAUD) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      #1 RX = b[i];
      repeat (BAUD) @(posedge clk);
    end
    #1 RX = stop_ok;
    repeat (BAUD) @(posedge clk);
  endtask

  task automatic settle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_clr();
    @(posedge clk);
    #1 clr_cmd_rdy = 1'b1;
    @(posedge clk);
    #1 clr_cmd_rdy = 1'b0;
  endtask

  // Monitor: turn observed output activity into events and match against the queue
  logic       prev_rdy = 1'b0;
  logic [7:0] prev_cmd = 8'h00;

  task automatic handle(input int kind);
    ev_t e;
    if (exp_q.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL unexpected_event: got kind %0d cmd 0x%0h at cycle %0d, want no event",
               kind, cmd, cyc);
    end else begin
      e = exp_q.pop_front();
      check("ev_kind", kind, e.kind);
      check("ev_cmd", cmd, e.data);
      check("ev_cycle", cyc, e.at);
      if (kind == K_LOAD) check("ev_rdy", cmd_rdy, 1'b1);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if ((cmd_rdy && !prev_rdy) || (cmd !== prev_cmd)) handle(K_LOAD);
      if (overrun) handle(K_OVR);
      if (frm_err) handle(K_FERR);
    end
    prev_rdy = cmd_rdy;
    prev_cmd = cmd;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, want $finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    RX = 1'b1;
    clr_cmd_rdy = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("reset", 8'h00);
    @(posedge clk);
    #1 rst = 1'b0;
    settle(5);

    // Single valid frame with exact latency
    send(8'h45, 1'b1, 1'b0, 8'h00);
    settle(20);
    check("go_cmd", cmd, 8'h45);
    check("go_rdy", cmd_rdy, 1'b1);
    pulse_clr();
    check("go_clr", cmd_rdy, 1'b0);

    // Overrun: second byte arrives with no clear in between
    send(8'hC3, 1'b1, 1'b0, 8'h45);
    settle(20);
    send(8'h00, 1'b1, 1'b1, 8'hC3);
    settle(20);
    check("ovr_cmd", cmd, 8'h00);
    check("ovr_rdy", cmd_rdy, 1'b1);
    pulse_clr();
    check("ovr_clr", cmd_rdy, 1'b0);

    // Short low glitch must not start a frame
    @(posedge clk);
    #1 RX = 1'b0;
    repeat (5) @(posedge clk);
    #1 RX = 1'b1;
    settle(40);
    check("glitch_rdy", cmd_rdy, 1'b0);
    check("glitch_cmd", cmd, 8'h00);

    // Framing error followed by a held-low break
    send(8'hA5, 1'b0, 1'b0, 8'h00);
    repeat (40) @(posedge clk);
    #1 RX = 1'b1;
    settle(40);
    check("ferr_rdy", cmd_rdy, 1'b0);
    check("ferr_cmd", cmd, 8'h00);

    // Clear coincident with frame completion: the new byte wins
    send(8'h33, 1'b1, 1'b0, 8'h00);
    settle(20);
    check("pre_rdy", cmd_rdy, 1'b1);
    fork
      send(8'h7E, 1'b1, 1'b0, 8'h33);
      begin
        @(posedge clk);
        repeat (LAT - 1) @(posedge clk);
        #1 clr_cmd_rdy = 1'b1;
        @(posedge clk);
        #1 clr_cmd_rdy = 1'b0;
      end
    join
    settle(20);
    check("race_rdy", cmd_rdy, 1'b1);
    check("race_cmd", cmd, 8'h7E);
    pulse_clr();
    check("race_clr", cmd_rdy, 1'b0);

    // Reset in the middle of the data bits of 8'hFF
    @(posedge clk);
    #1 RX = 1'b0;
    repeat (BAUD) @(posedge clk);
    #1 RX = 1'b1;
    repeat (40) @(posedge clk);
    #1 rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check_idle_outputs("midrst", 8'h00);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    settle(150);
    send(8'h12, 1'b1, 1'b0, 8'h00);
    settle(20);
    check("post_rst_cmd", cmd, 8'h12);
    check("post_rst_rdy", cmd_rdy, 1'b1);

    check("queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
